// File: rtl/apb_mem_completer.sv
// APB completer backed by a small register-file memory, answering the APB_Protocol bridge.
// Optional wait states are enabled with `define APB_COMPLETER_WAIT_EN (WAIT_CYCLES 0..15).
module apb_mem_completer #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic               write_q, write_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               err_q, err_d;
  logic               pready_q, pready_d;
  logic [DATA_W-1:0]  prdata_q, prdata_d;
  logic               pslverr_q, pslverr_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];
  logic               setup_err;
  logic               load_zero;

`ifdef APB_COMPLETER_WAIT_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  logic [3:0] cnt_q, cnt_d;
  assign load_zero = (WAIT_LOAD == 4'd0);
`else
  logic unused_wait_cycles;
  assign unused_wait_cycles = |WAIT_CYCLES;
  assign load_zero          = 1'b1;
`endif

  assign setup_err = ({1'b0, PADDR} >= DEPTH_LIM);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    pready_d  = pready_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    mem_d     = mem_q;
`ifdef APB_COMPLETER_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          addr_d  = PADDR[IDX_W-1:0];
          write_d = PWRITE;
          wdata_d = PWDATA;
          err_d   = setup_err;
`ifdef APB_COMPLETER_WAIT_EN
          cnt_d   = WAIT_LOAD;
`endif
          if (load_zero) begin
            pready_d  = 1'b1;
            pslverr_d = setup_err;
            prdata_d  = (!PWRITE && !setup_err) ? mem_q[PADDR[IDX_W-1:0]] : '0;
          end
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
`ifdef APB_COMPLETER_WAIT_EN
          cnt_d     = 4'd0;
`endif
        end else if (PENABLE) begin
          if (pready_q) begin
            // Writes commit only on the completing edge, using setup-phase values.
            if (write_q && !err_q) mem_d[addr_q] = wdata_q;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            state_d   = IDLE;
          end
`ifdef APB_COMPLETER_WAIT_EN
          else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              pready_d  = 1'b1;
              pslverr_d = err_q;
              prdata_d  = (!write_q && !err_q) ? mem_q[addr_q] : '0;
            end
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!PRESETn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      // NOTE: the memory is cleared on reset, so it is built from flops rather than a RAM macro.
      mem_q     <= '{default: '0};
`ifdef APB_COMPLETER_WAIT_EN
      cnt_q     <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      mem_q     <= mem_d;
`ifdef APB_COMPLETER_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign PREADY  = pready_q;
  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Directed bench for apb_mem_completer: transfers, sweep, range errors, waits, abort, reset, noise.
module tb_apb_mem_completer;

`ifdef APB_COMPLETER_WAIT_EN
  localparam int EXP_WAITS = 2;
`else
  localparam int EXP_WAITS = 0;
`endif

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic       PREADY;
  logic [7:0] PRDATA;
  logic       PSLVERR;

  int vectors = 0;
  int miscompares = 0;

  apb_mem_completer #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(2)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer; leaves the bus idle with no time consumed after the completing edge.
  task automatic xfer(input string tag, input logic w, input logic [7:0] addr,
                      input logic [7:0] wdata, input logic [7:0] exp_rdata, input logic exp_err);
    int n;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = addr; PWDATA = wdata;
    tick();
    PENABLE = 1'b1;
    PADDR   = ~addr;  // access-phase changes must be ignored
    PWDATA  = ~wdata;
    n = 0;
    while (PREADY !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_waits"}, n, EXP_WAITS);
    check({tag, "_pready"}, {31'd0, PREADY}, 1);
    check({tag, "_prdata"}, {24'd0, PRDATA}, {24'd0, exp_rdata});
    check({tag, "_pslverr"}, {31'd0, PSLVERR}, {31'd0, exp_err});
    tick();
    PSEL = 1'b0; PENABLE = 1'b0;
    check({tag, "_done"}, {31'd0, PREADY}, 0);
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    tick(); tick();
    check("rst_pready", {31'd0, PREADY}, 0);
    check("rst_prdata", {24'd0, PRDATA}, 0);
    check("rst_pslverr", {31'd0, PSLVERR}, 0);
    PRESETn = 1'b1;
    tick();

    xfer("wr3", 1'b1, 8'h03, 8'h0A, 8'h00, 1'b0);
    xfer("rd3", 1'b0, 8'h03, 8'h00, 8'h0A, 1'b0);
    xfer("wr13", 1'b1, 8'h0D, 8'h3C, 8'h00, 1'b0);
    xfer("wr_oor", 1'b1, 8'h2D, 8'h55, 8'h00, 1'b1);
    xfer("rd_oor", 1'b0, 8'h2D, 8'h00, 8'h00, 1'b1);
    xfer("rd13", 1'b0, 8'h0D, 8'h00, 8'h3C, 1'b0);
    xfer("wr15", 1'b1, 8'h0F, 8'hF0, 8'h00, 1'b0);
    xfer("rd15", 1'b0, 8'h0F, 8'h00, 8'hF0, 1'b0);
    xfer("rd16", 1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
    xfer("rdff", 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++) xfer($sformatf("sw_wr%0d", i), 1'b1, 8'(i), 8'(2 * i), 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) xfer($sformatf("sw_rd%0d", i), 1'b0, 8'(i), 8'h00, 8'(2 * i), 1'b0);

    xfer("b2b_wr9", 1'b1, 8'h09, 8'hA5, 8'h00, 1'b0);
    xfer("b2b_rd9", 1'b0, 8'h09, 8'h00, 8'hA5, 1'b0);
    xfer("wt_wr5", 1'b1, 8'h05, 8'h07, 8'h00, 1'b0);
    xfer("wt_rd5", 1'b0, 8'h05, 8'h00, 8'h07, 1'b0);

    // Abort: PSEL drops during the access phase of a write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h01; PWDATA = 8'h99;
    tick();
    PENABLE = 1'b1;
    PSEL = 1'b0;
    tick();
    PENABLE = 1'b0;
    check("abort_pready", {31'd0, PREADY}, 0);
    tick();
    check("abort_idle_pready", {31'd0, PREADY}, 0);
    xfer("abort_rd1", 1'b0, 8'h01, 8'h00, 8'h02, 1'b0);

    // Reset in the middle of an access phase.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h03;
    tick();
    PENABLE = 1'b1;
    PRESETn = 1'b0;
    tick();
    check("midrst_pready", {31'd0, PREADY}, 0);
    check("midrst_prdata", {24'd0, PRDATA}, 0);
    check("midrst_pslverr", {31'd0, PSLVERR}, 0);
    PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    xfer("postrst_rd1", 1'b0, 8'h01, 8'h00, 8'h00, 1'b0);
    xfer("postrst_rd3", 1'b0, 8'h03, 8'h00, 8'h00, 1'b0);

    // Protocol noise: access phase with no preceding setup.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h02; PWDATA = 8'h77;
    tick();
    check("noise_pready0", {31'd0, PREADY}, 0);
    tick();
    check("noise_pready1", {31'd0, PREADY}, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick();
    xfer("noise_rd2", 1'b0, 8'h02, 8'h00, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_mem_completer.md
Name: apb_mem_completer

Overview:
- APB completer (slave) that answers transfers from the team's APB_Protocol requester bridge.
- Backed by a register-file memory.
- Decodes setup and access phases, returns PREADY, PRDATA and PSLVERR, and commits writes on transfer completion.
- Two instances sit behind the bridge's PSEL fan-out, one per slave address half.

Parameters:
- ADDR_W, 8, PADDR width seen by this completer (bridge strips the slave-select MSB).
- DATA_W, 8, PWDATA/PRDATA width.
- DEPTH, 16, number of memory words; valid addresses are 0..DEPTH-1.
- WAIT_CYCLES, 0, extra access cycles before PREADY; only honoured when APB_COMPLETER_WAIT_EN is defined.

Ports:
- PCLK  input  1  APB clock, all logic on rising edge.
- PRESETn  input  1  synchronous, active-low reset, sampled on rising PCLK.
- PSEL  input  1  completer select.
- PENABLE  input  1  access-phase indicator.
- PWRITE  input  1  1=write, 0=read.
- PADDR  input  ADDR_W  word address.
- PWDATA  input  DATA_W  write data.
- PREADY  output  1  transfer completion, registered.
- PRDATA  output  DATA_W  read data, registered.
- PSLVERR  output  1  error response, registered; meaningful only while PREADY=1.

Behaviour:
- Reset (PRESETn=0 at a rising edge):
  - State=IDLE; PREADY=0, PRDATA=0, PSLVERR=0, wait counter=0.
  - All memory words cleared to 0.
  - Reset overrides any in-flight transfer; no write commits during a reset cycle.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Edge samples PSEL=1, PENABLE=0 (setup) -> latch PADDR, PWRITE, PWDATA; go to ACCESS.
  - err = (latched PADDR >= DEPTH).
  - Wait counter loads WAIT_CYCLES (0 without macro).
  - If the loaded count is 0: PREADY<=1, PSLVERR<=err, and PRDATA<=(read & !err) ? mem[PADDR] : 0.
  - PENABLE=1 while in IDLE (no preceding setup) is ignored; PREADY stays 0.
- ACCESS:
  - Counter > 0 at an edge with PSEL=1, PENABLE=1: decrement. On the edge where it goes 1->0, assert PREADY/PRDATA/PSLVERR as above.
  - PREADY=1 at an edge with PSEL=1, PENABLE=1 (completion):
    - If write and !err: mem[addr]<=wdata.
    - PREADY<=0, PSLVERR<=0, PRDATA holds last value.
    - Go to IDLE.
  - PSEL=0 at any edge (abort): return to IDLE, PREADY<=0, PSLVERR<=0, no write.
  - PADDR/PWDATA/PWRITE changes during ACCESS are ignored; setup-phase values are used.
- Latency: with 0 waits, PREADY is high in the first access cycle, so every transfer takes 2 cycles. With N waits, PREADY rises in access cycle N+1.
- Back-to-back transfers:
  - Setup on the cycle after completion is accepted (IDLE samples it).
  - A read of an address written by the immediately preceding transfer returns the new data.
- Errored write: PSLVERR=1 with PREADY; memory unchanged.
- Errored read: PRDATA=0.
- Address width: addresses compare as unsigned ADDR_W values; no wrap-around or aliasing.

Optional Feature:
- Macro: APB_COMPLETER_WAIT_EN.
- Defined: WAIT_CYCLES (0..15) is loaded into a 4-bit wait counter at setup, inserting that many PREADY=0 access cycles.
- Undefined: counter logic is absent; PREADY is always asserted in the first access cycle and WAIT_CYCLES is ignored.

Test Plan:
- Write then read, 0 waits: write PADDR=0x03, PWDATA=0x0A, then read 0x03 -> PREADY high in the 2nd cycle of each transfer, PRDATA=0x0A, PSLVERR=0.
- Sweep with back-to-back transfers: write mem[i]=2*i for i=0..7, then read 0..7 -> PRDATA=0x00,0x02,...,0x0E with no idle cycles between transfers.
- Out-of-range: write 0x55 to PADDR=0x2D (DEPTH=16), then read 0x2D -> PSLVERR=1 with PREADY on both transfers, PRDATA=0x00; a read of 0x0D still returns its prior value.
- Wait states (macro defined, WAIT_CYCLES=2): read 0x05 holding 0x07 -> PREADY=0 for access cycles 1-2 and =1 in cycle 3 with PRDATA=0x07. Without the macro, the same stimulus gives PREADY in access cycle 1.
- Abort/reset: drop PSEL mid-ACCESS on a write of 0x99 to 0x01 -> mem[1] unchanged and PREADY=0. Assert PRESETn=0 during ACCESS -> next cycle PREADY=0, PRDATA=0, and a read of 0x01 returns 0x00.
- Protocol noise: PENABLE=1 with PSEL=1 and no prior setup -> PREADY stays 0 and no memory write occurs.
